// File: rtl/lcd_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : lcd_scanout
//  Purpose  : Scans the 1-bpp Z88 framebuffer out of VRAM as a VGA-timed,
//             line-replicated serial pixel stream.
//  Revision : 1.0
// ============================================================================
module lcd_scanout #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter int VSCALE   = 4,
   parameter int V_OFFSET = 112
) (
   input  logic        mck,
   input  logic        rin,
   input  logic        pix_ce,
   input  logic        lcdon,
   output logic [12:0] o_rd_a,
   input  logic [7:0]  i_rd_d,
   output logic        o_hs,
   output logic        o_vs,
   output logic        o_de,
   output logic        o_pix,
   output logic        o_sof
);

   localparam int C_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int C_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int C_HW      = $clog2(C_H_TOTAL);
   localparam int C_VW      = $clog2(C_V_TOTAL);
   localparam int C_VSHIFT  = $clog2(VSCALE);

   localparam logic [C_HW-1:0] C_H_ACT    = C_HW'(H_ACTIVE);
   localparam logic [C_HW-1:0] C_H_MAX    = C_HW'(C_H_TOTAL - 1);
   localparam logic [C_HW-1:0] C_HS_BEG   = C_HW'(H_ACTIVE + H_FP);
   localparam logic [C_HW-1:0] C_HS_END   = C_HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [C_VW-1:0] C_V_ACT    = C_VW'(V_ACTIVE);
   localparam logic [C_VW-1:0] C_V_MAX    = C_VW'(C_V_TOTAL - 1);
   localparam logic [C_VW-1:0] C_VS_BEG   = C_VW'(V_ACTIVE + V_FP);
   localparam logic [C_VW-1:0] C_VS_END   = C_VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [C_VW-1:0] C_BAND_BEG = C_VW'(V_OFFSET);
   localparam logic [C_VW-1:0] C_BAND_END = C_VW'(V_OFFSET + 64 * VSCALE);
   localparam logic [6:0]      C_LAST_BYTE = 7'(H_ACTIVE / 8 - 1);

   logic [C_HW-1:0] r_hcnt;
   logic [C_VW-1:0] r_vcnt;
   logic [7:0]      r_sr;
   logic [7:0]      r_nxt;
   logic            r_pend1;
   logic            r_pend2;

   logic            w_h_last;
   logic            w_v_last;
   logic            w_h_act;
   logic            w_v_act;
   logic            w_byte_start;
   logic            w_in_band;
   logic            w_nx_band;
   logic            w_line_end;
   logic            w_load;
   logic            w_fetch_first;
   logic            w_fetch_next;
   logic            w_fetch;
   logic            w_pix_bit;
   logic            w_hs_n;
   logic            w_vs_n;
   logic [C_VW-1:0] w_vnext;
   logic [C_VW-1:0] w_voff_nx;
   logic [5:0]      w_zline_nx;

   assign w_h_last     = (r_hcnt == C_H_MAX);
   assign w_v_last     = (r_vcnt == C_V_MAX);
   assign w_h_act      = (r_hcnt < C_H_ACT);
   assign w_v_act      = (r_vcnt < C_V_ACT);
   assign w_byte_start = (r_hcnt[2:0] == 3'd0);
   assign w_vnext      = w_v_last ? '0 : r_vcnt + 1'b1;

   assign w_in_band  = (r_vcnt >= C_BAND_BEG) && (r_vcnt < C_BAND_END);
   assign w_nx_band  = (w_vnext >= C_BAND_BEG) && (w_vnext < C_BAND_END);
   assign w_voff_nx  = w_vnext - C_BAND_BEG;
   assign w_zline_nx = 6'(w_voff_nx >> C_VSHIFT);

   assign w_line_end = pix_ce && (r_hcnt == C_H_ACT);
   assign w_load     = pix_ce && w_byte_start && w_h_act;

   // The byte field stops at the last visible byte so cropped columns are never fetched.
   assign w_fetch_first = w_line_end && w_nx_band;
   assign w_fetch_next  = w_load && w_in_band && (o_rd_a[6:0] != C_LAST_BYTE);
   assign w_fetch       = w_fetch_first || w_fetch_next;

   assign w_pix_bit = w_byte_start ? r_nxt[0] : r_sr[1];
   assign w_hs_n    = !((r_hcnt >= C_HS_BEG) && (r_hcnt < C_HS_END));
   assign w_vs_n    = !((r_vcnt >= C_VS_BEG) && (r_vcnt < C_VS_END));

   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         r_hcnt <= '0;
         r_vcnt <= '0;
      end else if (pix_ce) begin
         if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_vnext;
         end else begin
            r_hcnt <= r_hcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         o_rd_a <= '0;
      end else if (w_fetch_first) begin
         o_rd_a <= {w_zline_nx, 7'd0};
      end else if (w_fetch_next) begin
         o_rd_a <= {o_rd_a[12:7], o_rd_a[6:0] + 7'd1};
      end
   end

   // Read data is valid one mck after the address moves; capture it one mck later still.
   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         r_pend1 <= 1'b0;
         r_pend2 <= 1'b0;
         r_nxt   <= '0;
      end else begin
         r_pend1 <= w_fetch;
         r_pend2 <= r_pend1;
         if (r_pend2) begin
            r_nxt <= i_rd_d;
         end
      end
   end

   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         r_sr <= '0;
      end else if (pix_ce) begin
         if (w_load) begin
            r_sr <= r_nxt;
         end else begin
            r_sr <= {1'b0, r_sr[7:1]};
         end
      end
   end

   always_ff @(posedge mck or posedge rin) begin
      if (rin) begin
         o_hs  <= 1'b1;
         o_vs  <= 1'b1;
         o_de  <= 1'b0;
         o_pix <= 1'b0;
         o_sof <= 1'b0;
      end else begin
         o_sof <= pix_ce && (r_hcnt == '0) && (r_vcnt == '0);
         if (pix_ce) begin
            o_hs  <= w_hs_n;
            o_vs  <= w_vs_n;
            o_de  <= w_h_act && w_v_act;
            o_pix <= lcdon && w_in_band && w_h_act && w_pix_bit;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_lcd_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lcd_scanout
//  Purpose  : Directed self-checking bench for lcd_scanout on a reduced raster.
//  Revision : 1.0
// ============================================================================
module tb_lcd_scanout;

   localparam int HA = 64, HFP = 4, HS = 8, HBP = 4, HT = HA + HFP + HS + HBP;
   localparam int VA = 136, VFP = 2, VS = 2, VBP = 3, VT = VA + VFP + VS + VBP;
   localparam int VSC = 2, VOFF = 3;

   logic        mck = 1'b0;
   logic        rin = 1'b1;
   logic        pix_ce = 1'b0;
   logic        lcdon = 1'b1;
   logic [12:0] rd_a;
   logic [7:0]  rd_d = 8'h00;
   logic        hs, vs, de, pix, sof;

   logic [7:0]  mem [0:8191];

   int          n_tests = 0;
   int          n_fail = 0;
   int          th = 0, tv = 0;
   logic [12:0] exp_addr = '0;

   bit          rec = 1'b0;
   logic [63:0] l2 = '0, l3 = '0, l4 = '0;
   int          hs_first = -1, hs_cnt = 0, vs_first = -1, vs_cnt = 0, sof_cnt = 0;
   logic [12:0] a_3_64, a_4_64, a_5_0, a_5_56, a_130_64, a_142_64;

   lcd_scanout #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .VSCALE(VSC), .V_OFFSET(VOFF)
   ) dut (
      .mck(mck), .rin(rin), .pix_ce(pix_ce), .lcdon(lcdon),
      .o_rd_a(rd_a), .i_rd_d(rd_d),
      .o_hs(hs), .o_vs(vs), .o_de(de), .o_pix(pix), .o_sof(sof)
   );

   always #5 mck = ~mck;
   always @(posedge mck) rd_d <= mem[rd_a];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, th, tv);
      end
   endtask

   function automatic bit in_band(input int v);
      return (v >= VOFF) && (v < VOFF + 64 * VSC);
   endfunction

   function automatic logic [5:0] zl(input int v);
      return 6'((v - VOFF) / VSC);
   endfunction

   task automatic chk_reset_state(input string tag);
      chk({tag, "_hs"}, 32'(hs), 32'd1);
      chk({tag, "_vs"}, 32'(vs), 32'd1);
      chk({tag, "_de"}, 32'(de), 32'd0);
      chk({tag, "_pix"}, 32'(pix), 32'd0);
      chk({tag, "_sof"}, 32'(sof), 32'd0);
      chk({tag, "_addr"}, 32'(rd_a), 32'd0);
   endtask

   // One pixel: `idle` mck cycles with pix_ce low, then one pix_ce cycle checked against the model.
   task automatic tick(input int idle);
      logic e_hs, e_vs, e_de, e_pix, e_sof;
      logic [7:0] b;
      int nv, nb;
      for (int i = 0; i < idle; i++) begin
         pix_ce = 1'b0;
         @(posedge mck); #1;
         chk("sof_idle", 32'(sof), 32'd0);
         chk("addr_idle", 32'(rd_a), 32'(exp_addr));
         @(negedge mck);
      end
      pix_ce = 1'b1;
      e_hs  = !((th >= HA + HFP) && (th < HA + HFP + HS));
      e_vs  = !((tv >= VA + VFP) && (tv < VA + VFP + VS));
      e_de  = (th < HA) && (tv < VA);
      e_sof = (th == 0) && (tv == 0);
      e_pix = 1'b0;
      if (lcdon && in_band(tv) && th < HA) begin
         b = mem[{zl(tv), 7'(th / 8)}];
         e_pix = b[th % 8];
      end
      nv = (tv == VT - 1) ? 0 : tv + 1;
      if (th == HA && in_band(nv)) begin
         exp_addr = {zl(nv), 7'd0};
      end else if (in_band(tv) && th < HA && th % 8 == 0) begin
         nb = th / 8 + 1;
         if (nb > HA / 8 - 1) nb = HA / 8 - 1;
         exp_addr = {zl(tv), 7'(nb)};
      end
      @(posedge mck); #1;
      chk("hs", 32'(hs), 32'(e_hs));
      chk("vs", 32'(vs), 32'(e_vs));
      chk("de", 32'(de), 32'(e_de));
      chk("pix", 32'(pix), 32'(e_pix));
      chk("sof", 32'(sof), 32'(e_sof));
      chk("addr", 32'(rd_a), 32'(exp_addr));
      if (rec) begin
         if (tv == 2 && th < HA) l2[th] = pix;
         if (tv == 3 && th < HA) l3[th] = pix;
         if (tv == 4 && th < HA) l4[th] = pix;
         if (tv == 0 && !hs) begin
            if (hs_first < 0) hs_first = th;
            hs_cnt++;
         end
         if (!vs) begin
            if (vs_first < 0) vs_first = tv;
            vs_cnt++;
         end
         if (sof) sof_cnt++;
         if (tv == 3 && th == 64)   a_3_64 = rd_a;
         if (tv == 4 && th == 64)   a_4_64 = rd_a;
         if (tv == 5 && th == 0)    a_5_0 = rd_a;
         if (tv == 5 && th == 56)   a_5_56 = rd_a;
         if (tv == 130 && th == 64) a_130_64 = rd_a;
         if (tv == 142 && th == 64) a_142_64 = rd_a;
      end
      @(negedge mck);
      pix_ce = 1'b0;
      th++;
      if (th == HT) begin
         th = 0;
         tv = (tv == VT - 1) ? 0 : tv + 1;
      end
   endtask

   initial begin
      for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
      for (int i = 0; i < 8; i++) mem[i] = 8'h00;
      mem[0] = 8'h01;
      mem[1] = 8'h80;

      // Reset held from time zero
      repeat (3) @(negedge mck);
      chk_reset_state("rst_init");
      rin = 1'b0;

      // Full frame plus one pixel, pix_ce every mck
      rec = 1'b1;
      for (int i = 0; i < HT * VT + 1; i++) tick(0);
      rec = 1'b0;
      chk("sof_count", 32'(sof_cnt), 32'd2);
      chk("hs_first", 32'(hs_first), 32'd68);
      chk("hs_width", 32'(hs_cnt), 32'd8);
      chk("vs_first", 32'(vs_first), 32'd138);
      chk("vs_pixels", 32'(vs_cnt), 32'd160);
      chk("line2_bits", 32'(l2[31:0] | l2[63:32]), 32'd0);
      chk("line3_lo", l3[31:0], 32'h0000_8001);
      chk("line3_hi", l3[63:32], 32'h0);
      chk("line4_lo", l4[31:0], 32'h0000_8001);
      chk("line4_hi", l4[63:32], 32'h0);
      chk("addr_3_64", 32'(a_3_64), 32'h0000);
      chk("addr_4_64", 32'(a_4_64), 32'h0080);
      chk("addr_5_0", 32'(a_5_0), 32'h0081);
      chk("addr_5_56", 32'(a_5_56), 32'h0087);
      chk("addr_130_64", 32'(a_130_64), 32'h1F87);
      chk("addr_142_64", 32'(a_142_64), 32'h1F87);

      // Asynchronous reset in the middle of a band line
      for (int i = 0; i < HT * 10 + 20; i++) tick(0);
      rin = 1'b1;
      #1;
      chk_reset_state("rst_async");
      for (int i = 0; i < 6; i++) begin
         pix_ce = ~pix_ce;
         @(negedge mck);
      end
      chk_reset_state("rst_hold");
      pix_ce = 1'b0;
      rin = 1'b0;
      th = 0; tv = 0; exp_addr = '0;

      // pix_ce every 4th mck through the top of the band
      tick(3);
      chk("sof_after_rst", 32'(sof), 32'd1);
      for (int i = 0; i < HT * 8; i++) tick(3);

      // lcdon low with a fully lit framebuffer, then raised mid-line
      rin = 1'b1;
      @(negedge mck);
      for (int i = 0; i < 8192; i++) mem[i] = 8'hFF;
      lcdon = 1'b0;
      rin = 1'b0;
      th = 0; tv = 0; exp_addr = '0;
      for (int i = 0; i < HT * 4 + 10; i++) tick(0);
      lcdon = 1'b1;
      tick(0);
      chk("lcdon_rise", 32'(pix), 32'd1);
      for (int i = 0; i < 20; i++) tick(0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lcd_scanout.md
# lcd_scanout

Display scan-out stage downstream of the Z88 screen renderer. Reads the 1-bpp framebuffer that the renderer writes into VRAM (64 lines × 128-byte stride) through a synchronous read port. Generates 640×480 VGA-style timing with line replication. Serialises each byte into a 1-bit pixel stream for the video DAC/LCD bridge.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync widths
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync widths
- VSCALE, 4, output lines per Z88 line (power of 2)
- V_OFFSET, 112, first visible line of the Z88 band
- mck  in  1  system clock; all logic on posedge
- rin  in  1  reset, asynchronous, active-high
- pix_ce  in  1  pixel clock enable; each high cycle advances one pixel
- lcdon  in  1  Blink LCD enable; 0 blanks the pixel data
- o_rd_a  out  13  VRAM read address {line[5:0], byte[6:0]}
- i_rd_d  in  8  VRAM read data, valid the mck cycle after o_rd_a changes
- o_hs  out  1  horizontal sync, active-low
- o_vs  out  1  vertical sync, active-low
- o_de  out  1  data enable, high in the 640×480 active area
- o_pix  out  1  pixel, 1 = lit
- o_sof  out  1  one-mck pulse at the start of each frame

## Operation
- hcnt runs 0..H_TOTAL-1 (800). vcnt runs 0..V_TOTAL-1 (525). Both advance only on pix_ce.
- hcnt wraps to 0 and increments vcnt. vcnt wraps to 0 after V_TOTAL-1.
- Z88 band: V_OFFSET ≤ vcnt < V_OFFSET+64·VSCALE.
  - zline = (vcnt−V_OFFSET)/VSCALE (6 bits).
  - Outside the band, o_pix=0 and no reads are issued.
- Each visible line shows bytes 0..79 of its zline. Byte columns 80..127 are never read, so the renderer's pixels beyond 640 are cropped.
- Bit order: byte bit 0 is the leftmost pixel. The shift register shifts right.
- Fetch pipeline:
  - Byte buffer nxt is captured from i_rd_d on the second mck cycle after each o_rd_a update (2-stage pending flag).
  - At hcnt==H_ACTIVE (line end), o_rd_a is set to {zline of next line, 7'd0}.
  - On pix_ce with hcnt[2:0]==0 and hcnt<H_ACTIVE: shift register loads nxt and o_rd_a byte field increments.
  - Otherwise the shift register shifts right by 1 on pix_ce.
- lcdon=0: o_pix forced 0. Timing, o_de and o_sof continue. Reads still occur.
- o_sof: high for one mck on the pix_ce edge where hcnt==0 and vcnt==0.

## Timing
- Outputs are registered and update only on mck edges with pix_ce=1, except o_sof, which is 0 on every other edge.
  - Values on each such edge are computed from the pre-increment (hcnt, vcnt).
  - Net latency: one pix_ce from counter position to output.
- o_hs=0 for H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC.
- o_vs=0 for V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC.
- o_de=1 for hcnt<H_ACTIVE and vcnt<V_ACTIVE.
- Read latency budget: 2 mck per byte. pix_ce may be high every cycle, since 8 pix_ce ≥ 2 mck. Line-start prefetch has 160 blank pixels of slack.
- Reset (rin=1, any time including mid-line):
  - Counters, shift register, nxt, pending flags and o_rd_a are set to 0. o_pix, o_de and o_sof are 0. o_hs and o_vs are 1.
  - After release, the first pix_ce emits position (0,0) with o_sof=1.
- Simultaneous wrap: the hcnt and vcnt wrap on the same pix_ce is legal. The frame restarts cleanly with no extra line.

## Test plan
- Reset/idle: assert rin mid-frame with pix_ce toggling -> o_hs=o_vs=1 and o_de=o_pix=o_sof=0 immediately (async). Release -> o_sof pulses on the first pix_ce.
- Sync timing, pix_ce every cycle -> o_hs low for exactly 96 pixels starting at pixel 656 of each 800-pixel line. o_vs low on lines 490–491. Frame is 420000 pix_ce long.
- Pixel order: VRAM line 0 byte 0=0x01, byte 1=0x80, rest 0 -> on vcnt 112..115, o_pix=1 at pixels 0 and 15 only. Lines 111 and 116 are unaffected by line 0 (line 116 shows line 1).
- Address sequence -> on vcnt=112, o_rd_a reads 0x0000..0x004F in order. On vcnt=116, o_rd_a reads 0x0080.. . No reads outside the band.
- pix_ce every 4th mck vs every mck with random VRAM -> identical o_pix sequences per pixel index. No stale or duplicated bytes at line starts.
- lcdon=0 with all VRAM 0xFF -> o_pix=0 everywhere. o_de/o_hs/o_vs are unchanged. Raising lcdon mid-frame -> lit pixels from the next pix_ce.
